// File: rtl/shot_sequencer.sv
// shot_sequencer: turn controller for the projectile game.
// Ports: clk/reset, fire/ack buttons, velocity switches, projectile position
// in; latched velocities, proj_clr/tick strobes, one-hot state flags,
// shots_left and score out.
module shot_sequencer #(
  parameter int TICK_CYCLES  = 50_000_000,
  parameter int MAX_TICKS    = 64,
  parameter int SHOTS        = 3,
  parameter int GROUND_Y     = 475,
  parameter int EDGE_X       = 775,
  parameter int TARGET_X_MIN = 650,
  parameter int TARGET_X_MAX = 675,
  parameter int PROJ_W       = 5,
  parameter int PROJ_H       = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fire,
  input  logic       ack,
  input  logic [3:0] vX_in,
  input  logic [3:0] vY_in,
  input  logic [9:0] proj_x,
  input  logic [9:0] proj_y,
  output logic [3:0] vX,
  output logic [3:0] vY,
  output logic       proj_clr,
  output logic       tick,
  output logic       q_Init,
  output logic       q_Aim,
  output logic       q_Animate,
  output logic       q_Hit,
  output logic       q_Miss,
  output logic       q_Done,
  output logic [2:0] shots_left,
  output logic [3:0] score
);

  localparam int TW = $clog2(TICK_CYCLES + 1);

  localparam logic [10:0] GY    = 11'(GROUND_Y);
  localparam logic [10:0] EX    = 11'(EDGE_X);
  localparam logic [10:0] TXMIN = 11'(TARGET_X_MIN);
  localparam logic [10:0] TXMAX = 11'(TARGET_X_MAX);
  localparam logic [10:0] PW    = 11'(PROJ_W);
  localparam logic [10:0] PH    = 11'(PROJ_H);

  typedef enum logic [2:0] {
    S_INIT,
    S_AIM,
    S_LAUNCH,
    S_FLIGHT,
    S_HIT,
    S_MISS,
    S_DONE
  } state_t;

  state_t state;
  state_t next;

  logic          fire_q;
  logic          ack_q;
  logic [TW-1:0] tcnt;
  logic [6:0]    step;

  logic        fire_edge;
  logic        ack_edge;
  logic        vel_nz;
  logic        tc_wrap;
  logic [10:0] x_sum;
  logic [10:0] y_sum;
  logic        landed;
  logic        on_tgt;
  logic        at_edge;
  logic        timeout;
  logic        judge;

  assign fire_edge = fire & ~fire_q;
  assign ack_edge  = ack & ~ack_q;
  assign vel_nz    = |{vX_in, vY_in};
  assign tc_wrap   = (tcnt == TW'(TICK_CYCLES - 1));

  // 11-bit sums so a box near column/row 1023 does not wrap to 0.
  assign x_sum = {1'b0, proj_x} + PW;
  assign y_sum = {1'b0, proj_y} + PH;

  // Rows 512..1023 are the projectile wrapped above the screen top.
  assign landed  = (y_sum >= GY) && !proj_y[9];
  assign on_tgt  = (x_sum >= TXMIN) && ({1'b0, proj_x} <= TXMAX);
  assign at_edge = (x_sum >= EX);
  assign timeout = (step == 7'(MAX_TICKS));

  // Position is only meaningful after the datapath has taken one step.
  assign judge = (step != 7'd0);

  always_comb begin
    next      = state;
    q_Init    = 1'b0;
    q_Aim     = 1'b0;
    q_Animate = 1'b0;
    q_Hit     = 1'b0;
    q_Miss    = 1'b0;
    q_Done    = 1'b0;
    proj_clr  = 1'b0;
    tick      = 1'b0;
    unique case (state)
      S_INIT: begin
        q_Init = 1'b1;
        next   = S_AIM;
      end
      S_AIM: begin
        q_Aim = 1'b1;
        if (fire_edge && vel_nz) next = S_LAUNCH;
      end
      S_LAUNCH: begin
        proj_clr = 1'b1;
        next     = S_FLIGHT;
      end
      S_FLIGHT: begin
        q_Animate = 1'b1;
        tick      = tc_wrap;
        if (judge) begin
          if (landed)
            next = on_tgt ? S_HIT : S_MISS;
          else if (at_edge || timeout)
            next = S_MISS;
        end
      end
      S_HIT, S_MISS: begin
        q_Hit  = (state == S_HIT);
        q_Miss = (state == S_MISS);
        if (ack_edge)
          next = (shots_left == 3'd0) ? S_DONE : S_AIM;
      end
      S_DONE: begin
        q_Done = 1'b1;
        if (ack_edge) next = S_INIT;
      end
      default: next = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_INIT;
      fire_q     <= 1'b0;
      ack_q      <= 1'b0;
      vX         <= 4'd0;
      vY         <= 4'd0;
      shots_left <= 3'(SHOTS);
      score      <= 4'd0;
      tcnt       <= '0;
      step       <= 7'd0;
    end else begin
      state  <= next;
      fire_q <= fire;
      ack_q  <= ack;

      if (state == S_AIM && next == S_LAUNCH) begin
        vX         <= vX_in;
        vY         <= vY_in;
        shots_left <= shots_left - 3'd1;
      end

      if (next == S_INIT) begin
        score      <= 4'd0;
        shots_left <= 3'(SHOTS);
      end

      if (state == S_FLIGHT && next == S_HIT && score != 4'hF)
        score <= score + 4'd1;

      if (state == S_FLIGHT) begin
        tcnt <= tc_wrap ? '0 : tcnt + TW'(1);
        if (tc_wrap) step <= step + 7'd1;
      end else begin
        tcnt <= '0;
        step <= 7'd0;
      end
    end
  end

endmodule

// File: tb/tb_shot_sequencer.sv
// tb_shot_sequencer: directed and random stimulus for shot_sequencer,
// checked every cycle against a behavioural model of the turn rules.
module tb_shot_sequencer;

  localparam int TC = 4;
  localparam int MT = 64;
  localparam int NS = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fire = 1'b0;
  logic       ack = 1'b0;
  logic [3:0] vX_in = 4'd0;
  logic [3:0] vY_in = 4'd0;
  logic [9:0] proj_x = 10'd100;
  logic [9:0] proj_y = 10'd100;

  logic [3:0] vX;
  logic [3:0] vY;
  logic       proj_clr;
  logic       tick;
  logic       q_Init;
  logic       q_Aim;
  logic       q_Animate;
  logic       q_Hit;
  logic       q_Miss;
  logic       q_Done;
  logic [2:0] shots_left;
  logic [3:0] score;

  int tests = 0;
  int fails = 0;
  int shown = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  shot_sequencer #(
    .TICK_CYCLES(TC),
    .MAX_TICKS(MT),
    .SHOTS(NS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .fire(fire),
    .ack(ack),
    .vX_in(vX_in),
    .vY_in(vY_in),
    .proj_x(proj_x),
    .proj_y(proj_y),
    .vX(vX),
    .vY(vY),
    .proj_clr(proj_clr),
    .tick(tick),
    .q_Init(q_Init),
    .q_Aim(q_Aim),
    .q_Animate(q_Animate),
    .q_Hit(q_Hit),
    .q_Miss(q_Miss),
    .q_Done(q_Done),
    .shots_left(shots_left),
    .score(score)
  );

  // Behavioural model: phase of the turn plus the number of cycles spent
  // in flight; ticks and completed steps follow from that age by division.
  typedef enum int {
    M_INIT, M_AIM, M_LAUNCH, M_FLIGHT, M_HIT, M_MISS, M_DONE
  } mph_t;

  mph_t ph = M_INIT;
  int   age = 0;
  int   m_score = 0;
  int   m_shots = NS;
  int   m_vx = 0;
  int   m_vy = 0;
  bit   pf = 1'b0;
  bit   pa = 1'b0;

  always @(posedge clk) begin : model
    mph_t n_ph;
    int   n_age, n_score, n_shots, n_vx, n_vy, steps;
    bit   fe, ae, landed, on_tgt, exit_now;
    fe = fire && !pf;
    ae = ack && !pa;
    n_ph = ph;
    n_age = age;
    n_score = m_score;
    n_shots = m_shots;
    n_vx = m_vx;
    n_vy = m_vy;
    if (reset) begin
      n_ph = M_INIT;
      n_age = 0;
      n_score = 0;
      n_shots = NS;
      n_vx = 0;
      n_vy = 0;
    end else begin
      case (ph)
        M_INIT: n_ph = M_AIM;
        M_AIM:
          if (fe && (vX_in != 0 || vY_in != 0)) begin
            n_ph = M_LAUNCH;
            n_vx = vX_in;
            n_vy = vY_in;
            n_shots = m_shots - 1;
          end
        M_LAUNCH: begin
          n_ph = M_FLIGHT;
          n_age = 0;
        end
        M_FLIGHT: begin
          steps = age / TC;
          exit_now = 1'b0;
          if (steps >= 1) begin
            landed = (int'(proj_y) + 2 >= 475) && (int'(proj_y) < 512);
            on_tgt = (int'(proj_x) + 5 >= 650) && (int'(proj_x) <= 675);
            if (landed) begin
              exit_now = 1'b1;
              if (on_tgt) begin
                n_ph = M_HIT;
                n_score = (m_score < 15) ? m_score + 1 : 15;
              end else begin
                n_ph = M_MISS;
              end
            end else if (int'(proj_x) + 5 >= 775 || steps == MT) begin
              exit_now = 1'b1;
              n_ph = M_MISS;
            end
          end
          if (!exit_now) n_age = age + 1;
        end
        M_HIT, M_MISS:
          if (ae) n_ph = (m_shots == 0) ? M_DONE : M_AIM;
        M_DONE:
          if (ae) begin
            n_ph = M_INIT;
            n_score = 0;
            n_shots = NS;
          end
        default: n_ph = M_INIT;
      endcase
    end
    ph <= n_ph;
    age <= n_age;
    m_score <= n_score;
    m_shots <= n_shots;
    m_vx <= n_vx;
    m_vy <= n_vy;
    pf <= reset ? 1'b0 : fire;
    pa <= reset ? 1'b0 : ack;
  end

  always @(negedge clk) begin : cmp
    logic [22:0] got, want;
    bit          m_tick;
    if (chk_en) begin
      m_tick = (ph == M_FLIGHT) && (age % TC == TC - 1);
      got = {q_Init, q_Aim, q_Animate, q_Hit, q_Miss, q_Done,
             proj_clr, tick, vX, vY, shots_left, score};
      want = {ph == M_INIT, ph == M_AIM, ph == M_FLIGHT,
              ph == M_HIT, ph == M_MISS, ph == M_DONE,
              ph == M_LAUNCH, m_tick, 4'(m_vx), 4'(m_vy),
              3'(m_shots), 4'(m_score)};
      tests++;
      if (got !== want) begin
        fails++;
        if (shown < 20) begin
          shown++;
          $display("FAIL outputs @%0t: got %b, expected %b",
                   $time, got, want);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic launch(input logic [3:0] vx, input logic [3:0] vy);
    vX_in = vx;
    vY_in = vy;
    fire = 1'b1;
    cyc(1);
    fire = 1'b0;
    cyc(1);
    check("launch reaches flight", q_Animate, 1);
  endtask

  task automatic fly(input logic [9:0] px, input logic [9:0] py);
    int n;
    cyc(5);
    proj_x = px;
    proj_y = py;
    n = 0;
    while (!(q_Hit || q_Miss) && n < 20) begin
      cyc(1);
      n++;
    end
    check("flight judged", q_Hit | q_Miss, 1);
    proj_x = 10'd100;
    proj_y = 10'd100;
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
  endtask

  int xs[12] = '{640, 644, 645, 650, 675, 676, 680, 769, 770, 771, 300, 0};
  int ys[9]  = '{472, 473, 474, 475, 511, 512, 1000, 100, 0};

  initial begin
    int n, ticks;
    reset = 1'b1;
    cyc(3);
    chk_en = 1'b1;
    check("reset q_Init", q_Init, 1);
    check("reset score", score, 0);
    check("reset shots_left", shots_left, 3);
    check("reset vX", vX, 0);
    reset = 1'b0;
    cyc(1);
    check("aim after init", q_Aim, 1);

    vX_in = 4'd3;
    vY_in = 4'd0;
    fire = 1'b1;
    cyc(1);
    check("launch proj_clr", proj_clr, 1);
    check("launch shots_left", shots_left, 2);
    check("launch flags low",
          {q_Init, q_Aim, q_Animate, q_Hit, q_Miss, q_Done}, 0);
    fire = 1'b0;
    cyc(1);
    check("flight flag", q_Animate, 1);
    check("latched vX", vX, 3);
    check("latched vY", vY, 0);
    cyc(3);
    check("first tick", tick, 1);
    cyc(2);
    proj_x = 10'd660;
    proj_y = 10'd473;
    cyc(1);
    check("hit flag", q_Hit, 1);
    check("hit score", score, 1);
    proj_x = 10'd100;
    proj_y = 10'd100;
    ack_pulse();
    check("ack to aim", q_Aim, 1);
    cyc(1);

    vX_in = 4'd0;
    vY_in = 4'd0;
    fire = 1'b1;
    cyc(1);
    check("zero vel stays aim", q_Aim, 1);
    check("zero vel no proj_clr", proj_clr, 0);
    check("zero vel shots", shots_left, 2);
    fire = 1'b0;
    cyc(1);

    launch(4'd5, 4'd7);
    fly(10'd300, 10'd474);
    check("ground miss", q_Miss, 1);
    check("miss score kept", score, 1);
    ack_pulse();
    check("shots after 2", shots_left, 1);

    launch(4'd9, 4'd1);
    fly(10'd771, 10'd100);
    check("edge miss", q_Miss, 1);
    ack_pulse();
    check("round done", q_Done, 1);
    check("done shots", shots_left, 0);
    fire = 1'b1;
    cyc(1);
    fire = 1'b0;
    cyc(1);
    check("done ignores fire", q_Done, 1);
    ack_pulse();
    check("new round init", q_Init, 1);
    cyc(1);
    check("new round aim", q_Aim, 1);
    check("new round score", score, 0);
    check("new round shots", shots_left, 3);

    launch(4'd1, 4'd1);
    proj_y = 10'd1000;
    n = 0;
    ticks = 0;
    while (!(q_Hit || q_Miss) && n < 400) begin
      if (tick) ticks++;
      n++;
      cyc(1);
    end
    check("timeout miss", q_Miss, 1);
    check("timeout ticks", ticks, 64);
    check("timeout flight cycles", n, 257);
    proj_y = 10'd100;
    ack_pulse();

    launch(4'd2, 4'd3);
    fly(10'd645, 10'd475);
    check("boundary hit", q_Hit, 1);
    check("boundary hit score", score, 1);
    ack_pulse();

    launch(4'd4, 4'd4);
    cyc(6);
    reset = 1'b1;
    fire = 1'b1;
    cyc(1);
    check("midflight reset init", q_Init, 1);
    check("midflight reset tick", tick, 0);
    check("midflight reset score", score, 0);
    check("midflight reset vX", vX, 0);
    check("midflight reset vY", vY, 0);
    cyc(1);
    reset = 1'b0;
    cyc(3);
    check("held fire no launch", q_Aim, 1);
    fire = 1'b0;
    cyc(1);

    for (int i = 0; i < 4000; i++) begin
      fire = ($urandom_range(0, 5) == 0);
      ack = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 7) == 0) begin
        vX_in = 4'd0;
        vY_in = 4'd0;
      end else begin
        vX_in = 4'($urandom);
        vY_in = 4'($urandom);
      end
      if ($urandom_range(0, 9) == 0) begin
        n = $urandom_range(0, 11);
        proj_x = (xs[n] == 0) ? 10'($urandom) : 10'(xs[n]);
        n = $urandom_range(0, 8);
        proj_y = (ys[n] == 0) ? 10'($urandom) : 10'(ys[n]);
      end else begin
        proj_x = 10'd100;
        proj_y = 10'd100;
      end
      reset = ($urandom_range(0, 999) == 0);
      cyc(1);
    end
    reset = 1'b0;
    fire = 1'b0;
    ack = 1'b0;
    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
